// File: rtl/glitchless_pkg.sv
// Shared types and defaults for the glitchless read-handshake subsystem.
package glitchless_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, READY} resp_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_WAIT_W = 4;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/glitchless_responder.sv
// Memory-side responder for the go/ws/rd/ds read handshake: wait-state insertion,
// data return, saturating completion count and a sticky protocol-error flag.
module glitchless_responder
  import glitchless_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                WAIT_W    = DEF_WAIT_W,
  parameter int                CNT_W     = DEF_CNT_W,
  parameter logic [DATA_W-1:0] DATA_SEED = 'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              ds,
  input  logic [WAIT_W-1:0] wait_cfg,
  input  logic              err_clr,
  output logic              ws,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [CNT_W-1:0]  txn_cnt,
  output logic              proto_err
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  resp_state_t       r_state, w_state;
  logic [WAIT_W-1:0] r_cnt, w_cnt;
  logic              r_ws, w_ws;
  logic              r_rvalid, w_rvalid;
  logic [DATA_W-1:0] r_rdata, w_rdata;
  logic [DATA_W-1:0] r_word, w_word;
  logic [CNT_W-1:0]  r_txn, w_txn;
  logic              r_err, w_err;
  logic              r_rd_q;
  logic              w_rd_rise;
  logic              w_err_set;

  assign w_rd_rise = rd & ~r_rd_q;

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_ws      = r_ws;
    w_rvalid  = r_rvalid;
    w_rdata   = r_rdata;
    w_word    = r_word;
    w_txn     = r_txn;
    w_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        w_ws     = 1'b0;
        w_rvalid = 1'b0;
        if (ds) begin
          w_err_set = 1'b1;
        end else if (w_rd_rise) begin
          w_cnt = wait_cfg;
          if (wait_cfg != '0) begin
            w_state = WAIT;
            w_ws    = 1'b1;
          end else begin
            w_state  = READY;
            w_rvalid = 1'b1;
            w_rdata  = r_word;
          end
        end
      end
      WAIT: begin
        if (!rd || ds) begin
          w_err_set = 1'b1;
          w_ws      = 1'b0;
          w_state   = IDLE;
        end else if (r_cnt == WAIT_W'(1)) begin
          w_state  = READY;
          w_ws     = 1'b0;
          w_rvalid = 1'b1;
          w_rdata  = r_word;
        end else begin
          w_cnt = r_cnt - WAIT_W'(1);
        end
      end
      READY: begin
        if (rd && !ds) begin
          w_ws     = 1'b0;
          w_rvalid = 1'b1;
        end else if (!rd && ds) begin
          w_rvalid = 1'b0;
          w_txn    = sat_inc(r_txn);
          w_word   = r_word + DATA_W'(1);
          w_state  = IDLE;
        end else begin
          // Abandoned or overlapping strobe: drop the word without consuming it.
          w_err_set = 1'b1;
          w_rvalid  = 1'b0;
          w_state   = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
    w_err = w_err_set ? 1'b1 : (err_clr ? 1'b0 : r_err);
  end

  // Register stage: every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ws     <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_word   <= DATA_SEED;
      r_txn    <= '0;
      r_err    <= 1'b0;
      r_rd_q   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_ws     <= w_ws;
      r_rvalid <= w_rvalid;
      r_rdata  <= w_rdata;
      r_word   <= w_word;
      r_txn    <= w_txn;
      r_err    <= w_err;
      r_rd_q   <= rd;
    end
  end

  assign ws        = r_ws;
  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign txn_cnt   = r_txn;
  assign proto_err = r_err;

endmodule

// File: tb/tb_glitchless_responder.sv
// Transaction-level bench for glitchless_responder: directed scenarios followed by
// randomized reads checked against expected word/count/error bookkeeping.
module tb_glitchless_responder;

  localparam int DATA_W = 8;
  localparam int WAIT_W = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              rd;
  logic              ds;
  logic [WAIT_W-1:0] wait_cfg;
  logic              err_clr;
  logic              ws;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [CNT_W-1:0]  txn_cnt;
  logic              proto_err;

  glitchless_responder #(
    .DATA_W(DATA_W), .WAIT_W(WAIT_W), .CNT_W(CNT_W), .DATA_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .rd(rd), .ds(ds), .wait_cfg(wait_cfg),
    .err_clr(err_clr), .ws(ws), .rdata(rdata), .rvalid(rvalid),
    .txn_cnt(txn_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_word;
  int          exp_cnt;
  logic        exp_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ws"}, 32'(ws), 32'd0);
    check({tag, ".rvalid"}, 32'(rvalid), 32'd0);
    check({tag, ".txn_cnt"}, 32'(txn_cnt), 32'(exp_cnt));
    check({tag, ".proto_err"}, 32'(proto_err), 32'(exp_err));
  endtask

  task automatic model_reset();
    exp_word = 8'hA5;
    exp_cnt  = 0;
    exp_err  = 1'b0;
  endtask

  // kind: 0 good completion, 1 rd dropped in WAIT at wait cycle 'drop',
  //       2 rd released without ds, 3 ds while rd still high.
  task automatic do_read(input int w, input int h, input int kind, input int drop);
    rd = 1'b1; ds = 1'b0; wait_cfg = WAIT_W'(w);
    step();
    wait_cfg = WAIT_W'($urandom);
    for (int i = 0; i < w; i++) begin
      check("wait.ws", 32'(ws), 32'd1);
      check("wait.rvalid", 32'(rvalid), 32'd0);
      if (kind == 1 && i == drop) begin
        rd = 1'b0;
        step();
        exp_err = 1'b1;
        check_idle("abort");
        return;
      end
      step();
    end
    for (int j = 0; j <= h; j++) begin
      check("ready.ws", 32'(ws), 32'd0);
      check("ready.rvalid", 32'(rvalid), 32'd1);
      check("ready.rdata", 32'(rdata), 32'(exp_word));
      if (j < h) step();
    end
    case (kind)
      0: begin
        rd = 1'b0; ds = 1'b1;
        step();
        ds = 1'b0;
        if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        exp_word = exp_word + 8'd1;
      end
      2: begin
        rd = 1'b0;
        step();
        exp_err = 1'b1;
      end
      default: begin
        ds = 1'b1;
        step();
        rd = 1'b0; ds = 1'b0;
        exp_err = 1'b1;
      end
    endcase
    check_idle("end");
  endtask

  task automatic idle_cycle(input logic clr, input logic dsp);
    rd = 1'b0; ds = dsp; err_clr = clr;
    step();
    ds = 1'b0; err_clr = 1'b0;
    if (dsp) exp_err = 1'b1;
    else if (clr) exp_err = 1'b0;
    check_idle("idle");
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; ds = 1'b0; wait_cfg = '0; err_clr = 1'b0;
    model_reset();
    step();
    step();
    reset = 1'b0;
    check_idle("reset");
    check("reset.rdata", 32'(rdata), 32'd0);

    // T1 zero-wait read, T2 three waits
    do_read(0, 1, 0, 0);
    do_read(3, 0, 0, 0);
    // T3 back-to-back single-wait reads
    do_read(1, 0, 0, 0);
    do_read(1, 0, 0, 0);
    // T4 ds in IDLE, clear, set-with-clear
    idle_cycle(1'b0, 1'b1);
    idle_cycle(1'b1, 1'b0);
    idle_cycle(1'b1, 1'b1);
    idle_cycle(1'b1, 1'b0);
    // T5 rd drops mid-wait
    do_read(5, 0, 1, 2);
    idle_cycle(1'b1, 1'b0);

    // T6 reset during WAIT
    rd = 1'b1; wait_cfg = 4'd5;
    step();
    step();
    check("t6.ws", 32'(ws), 32'd1);
    reset = 1'b1; rd = 1'b0;
    step();
    reset = 1'b0;
    model_reset();
    check_idle("t6.reset");
    check("t6.rdata", 32'(rdata), 32'd0);
    do_read(2, 0, 0, 0);

    // Randomized transactions: exercises count saturation and data-word wrap.
    for (int t = 0; t < 300; t++) begin
      int w, h, kind, drop, r;
      w    = int'($urandom_range(0, 15));
      h    = int'($urandom_range(0, 2));
      r    = int'($urandom_range(0, 9));
      kind = (r < 5 || r == 9) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : 3;
      if (kind == 1 && w == 0) kind = 2;
      drop = (w > 0) ? int'($urandom_range(0, w - 1)) : 0;
      do_read(w, h, kind, drop);
      if (kind != 0 || $urandom_range(0, 1) == 1)
        idle_cycle(logic'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
